// File: rtl/cv32e40s_pkg.sv
// Shared cv32e40s types used by the instruction-side OBI responder.
package cv32e40s_pkg;

  localparam int INSTR_OBI_MAX_OUTSTANDING = 2;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_inst_resp_t;

endpackage

// File: rtl/cv32e40s_instr_resp_fifo.sv
// In-order response FIFO; occupancy tracked by a separate count so pointers
// may wrap modulo an arbitrary DEPTH.
module cv32e40s_instr_resp_fifo
  import cv32e40s_pkg::*;
#(
  parameter int DEPTH = INSTR_OBI_MAX_OUTSTANDING
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push_i,
  input  obi_inst_resp_t push_data_i,
  input  logic           pop_i,
  output obi_inst_resp_t head_o,
  output logic           empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  obi_inst_resp_t       mem_q [DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wrap_inc(wr_ptr_q);
      end
      if (pop_i) rd_ptr_q <= wrap_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);

`ifndef SYNTHESIS
  logic full;
  assign full = (count_q == CW'(DEPTH));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push_i && full));
`endif

endmodule

// File: rtl/cv32e40s_instr_obi_responder.sv
// Instruction OBI responder: range check, one-cycle memory stage, bypass to
// the response port when nothing is queued, in-order FIFO otherwise.
module cv32e40s_instr_obi_responder
  import cv32e40s_pkg::*;
#(
  parameter int          DEPTH     = INSTR_OBI_MAX_OUTSTANDING,
  parameter int          MEM_AW    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              obi_req_i,
  output logic              obi_gnt_o,
  input  logic [31:0]       obi_addr_i,
  input  logic [2:0]        obi_prot_i,
  output logic              obi_rvalid_o,
  input  logic              obi_rready_i,
  output logic [31:0]       obi_rdata_o,
  output logic              obi_err_o,
  output logic              mem_req_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              busy_o
);

  localparam int              CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [32:0]     WINDOW  = 33'(1) << (MEM_AW + 2);

  logic [31:0]       offset;
  logic              in_range, accept, retire;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              s1_valid_q, s1_err_q;
  logic [MEM_AW-1:0] mem_addr_q;
  obi_inst_resp_t    s1_resp, out_resp, hold_q, fifo_head;
  logic              fifo_empty, fifo_push, fifo_pop;
  logic              unused_prot;

  assign unused_prot = ^obi_prot_i;

  // 33-bit compare keeps the window test correct even for MEM_AW = 30.
  assign offset     = obi_addr_i - BASE_ADDR;
  assign in_range   = ({1'b0, offset} < WINDOW);
  assign obi_gnt_o  = (cnt_q < DEPTH_C);
  assign accept     = obi_req_i && obi_gnt_o;
  assign mem_req_o  = accept && in_range;
  assign mem_addr_o = mem_req_o ? offset[MEM_AW+1:2] : mem_addr_q;
  assign busy_o     = (cnt_q != '0);

  always_comb begin
    s1_resp.rdata = s1_err_q ? 32'h0 : mem_rdata_i;
    s1_resp.err   = s1_err_q;
    obi_rvalid_o  = !fifo_empty || s1_valid_q;
    if (!fifo_empty)     out_resp = fifo_head;
    else if (s1_valid_q) out_resp = s1_resp;
    else                 out_resp = hold_q;
  end

  assign obi_rdata_o = out_resp.rdata;
  assign obi_err_o   = out_resp.err;
  assign retire      = obi_rvalid_o && obi_rready_i;
  assign fifo_pop    = !fifo_empty && obi_rready_i;
  // Stage-1 result is queued unless it was bypassed and taken this cycle.
  assign fifo_push   = s1_valid_q && !(fifo_empty && obi_rready_i);

  always_comb begin
    case ({accept, retire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      mem_addr_q <= '0;
      hold_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      s1_valid_q <= accept;
      s1_err_q   <= accept && !in_range;
      if (mem_req_o)    mem_addr_q <= offset[MEM_AW+1:2];
      if (obi_rvalid_o) hold_q     <= out_resp;
    end
  end

  cv32e40s_instr_resp_fifo #(.DEPTH(DEPTH)) u_resp_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (s1_resp),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty)
  );

`ifndef SYNTHESIS
  a_cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt_q <= DEPTH_C);
  a_rsp_stable: assert property (@(posedge clk) disable iff (rst)
    (obi_rvalid_o && !obi_rready_i) |=>
    (obi_rvalid_o && $stable(obi_rdata_o) && $stable(obi_err_o)));
  a_memreq_accept: assert property (@(posedge clk) disable iff (rst) mem_req_o |-> accept);
`endif

endmodule

// File: tb/tb_cv32e40s_instr_obi_responder.sv
// Scoreboard bench for the instruction OBI responder.
module tb_cv32e40s_instr_obi_responder;
  import cv32e40s_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        obiReq = 1'b0;
  logic        obiRready = 1'b1;
  logic [31:0] obiAddr = 32'h0;
  logic [2:0]  obiProt = 3'b100;
  logic        obiGnt, obiRvalid, obiErr, memReq, busy;
  logic [31:0] obiRdata;
  logic [11:0] memAddr;
  logic [31:0] memRdata = 32'h0;

  logic [31:0] tbMem [4096];
  localparam logic [31:0] WORDS [8] = '{
    32'h0000_0013, 32'h0041_0113, 32'h0081_0193, 32'h00C1_8213,
    32'h0102_0293, 32'h0142_8313, 32'h0183_0393, 32'h01C3_8413 };

  obi_inst_resp_t expQ [$];
  int             assertCount = 0;
  int             failCount = 0;
  logic [11:0]    lastMemAddr = 12'h0;

  always #5 clk = ~clk;

  cv32e40s_instr_obi_responder #(
    .DEPTH(2), .MEM_AW(12), .BASE_ADDR(32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .obi_req_i    (obiReq),
    .obi_gnt_o    (obiGnt),
    .obi_addr_i   (obiAddr),
    .obi_prot_i   (obiProt),
    .obi_rvalid_o (obiRvalid),
    .obi_rready_i (obiRready),
    .obi_rdata_o  (obiRdata),
    .obi_err_o    (obiErr),
    .mem_req_o    (memReq),
    .mem_addr_o   (memAddr),
    .mem_rdata_i  (memRdata),
    .busy_o       (busy)
  );

  // Synchronous single-port memory: data one cycle after the strobe.
  always @(posedge clk) begin
    if (memReq) memRdata <= tbMem[memAddr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every retired response is compared against the queue head.
  always @(negedge clk) begin
    obi_inst_resp_t exp;
    if (!rst && obiRvalid && obiRready) begin
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected_rsp: got 0x%08h err %0b, expected no response",
                 obiRdata, obiErr);
      end else begin
        exp = expQ.pop_front();
        checkOutput("rsp_rdata", obiRdata, exp.rdata);
        checkOutput("rsp_err", {31'b0, obiErr}, {31'b0, exp.err});
      end
    end
  end

  // Issues one fetch, waiting (bounded) for the grant, and records its response.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] expData,
                               input logic expErr);
    int waitCycles;
    waitCycles = 0;
    obiReq  = 1'b1;
    obiAddr = addr;
    @(negedge clk);
    while (!obiGnt && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!obiGnt) begin
      checkOutput("gnt_timeout", {31'b0, obiGnt}, 32'h1);
    end else begin
      expQ.push_back(obi_inst_resp_t'{rdata: expData, err: expErr});
      checkOutput("mem_req", {31'b0, memReq}, {31'b0, !expErr});
      if (!expErr) lastMemAddr = addr[13:2];
      checkOutput("mem_addr", {20'b0, memAddr}, {20'b0, lastMemAddr});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    obiReq = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: run exceeded time limit, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waitCycles;
    for (int i = 0; i < 4096; i++) tbMem[i] = 32'h0;
    for (int i = 0; i < 8; i++) tbMem[i] = WORDS[i];
    tbMem[12'hFFF] = 32'hCAFE_F00D;

    // Reset values while reset is held
    #12;
    checkOutput("rst_gnt",    {31'b0, obiGnt},    32'h1);
    checkOutput("rst_rvalid", {31'b0, obiRvalid}, 32'h0);
    checkOutput("rst_rdata",  obiRdata,           32'h0);
    checkOutput("rst_err",    {31'b0, obiErr},    32'h0);
    checkOutput("rst_memreq", {31'b0, memReq},    32'h0);
    checkOutput("rst_memaddr",{20'b0, memAddr},   32'h0);
    checkOutput("rst_busy",   {31'b0, busy},      32'h0);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] back-to-back fetch");
    obiRready = 1'b1;
    applyStimulus(32'h0, WORDS[0], 1'b0);
    applyStimulus(32'h4, WORDS[1], 1'b0);
    obiReq = 1'b0;
    @(negedge clk);
    checkOutput("b2b_rvalid_t2", {31'b0, obiRvalid}, 32'h1);
    checkOutput("b2b_rdata_t2",  obiRdata,           WORDS[1]);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("b2b_rvalid_t3", {31'b0, obiRvalid}, 32'h0);
    checkOutput("b2b_busy_t3",   {31'b0, busy},      32'h0);
    idle(1);

    $display("[TB] address window edges");
    applyStimulus(32'h0000_4000, 32'h0,          1'b1);
    applyStimulus(32'h0000_3FFC, 32'hCAFE_F00D,  1'b0);
    applyStimulus(32'hFFFF_FFFC, 32'h0,          1'b1);
    idle(3);

    $display("[TB] backpressure");
    obiRready = 1'b0;
    applyStimulus(32'h0, WORDS[0], 1'b0);
    applyStimulus(32'h4, WORDS[1], 1'b0);
    obiReq  = 1'b1;
    obiAddr = 32'h8;
    repeat (3) begin
      @(negedge clk);
      checkOutput("bp_gnt",    {31'b0, obiGnt},    32'h0);
      checkOutput("bp_rvalid", {31'b0, obiRvalid}, 32'h1);
      checkOutput("bp_rdata",  obiRdata,           WORDS[0]);
      checkOutput("bp_memreq", {31'b0, memReq},    32'h0);
      @(posedge clk);
      #1;
    end
    obiRready = 1'b1;
    @(negedge clk);
    checkOutput("bp_gnt_retire_cycle", {31'b0, obiGnt}, 32'h0);
    @(posedge clk);
    #1;
    obiRready = 1'b0;
    @(negedge clk);
    checkOutput("bp_gnt_reopen", {31'b0, obiGnt}, 32'h1);
    expQ.push_back(obi_inst_resp_t'{rdata: WORDS[2], err: 1'b0});
    checkOutput("bp_memreq_reopen", {31'b0, memReq}, 32'h1);
    lastMemAddr = 12'h002;
    @(posedge clk);
    #1;
    obiReq    = 1'b0;
    obiRready = 1'b1;
    idle(4);

    $display("[TB] accept and retire in the same cycle");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(32'(i * 4), WORDS[i], 1'b0);
      checkOutput("steady_busy",   {31'b0, busy},      32'h1);
      checkOutput("steady_gnt",    {31'b0, obiGnt},    32'h1);
      checkOutput("steady_rvalid", {31'b0, obiRvalid}, 32'h1);
    end
    idle(3);

    $display("[TB] mixed ok/err ordering");
    obiRready = 1'b1;
    applyStimulus(32'h0000_0008, WORDS[2], 1'b0);
    obiRready = 1'b0;
    applyStimulus(32'h0001_0000, 32'h0,    1'b1);
    obiRready = 1'b1;
    applyStimulus(32'h0000_000C, WORDS[3], 1'b0);
    idle(4);

    $display("[TB] reset mid-flight");
    obiRready = 1'b0;
    applyStimulus(32'h0, WORDS[0], 1'b0);
    applyStimulus(32'h4, WORDS[1], 1'b0);
    obiReq = 1'b0;
    checkOutput("pre_rst_gnt",  {31'b0, obiGnt}, 32'h0);
    checkOutput("pre_rst_busy", {31'b0, busy},   32'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_rvalid", {31'b0, obiRvalid}, 32'h0);
    checkOutput("mid_rst_rdata",  obiRdata,           32'h0);
    checkOutput("mid_rst_err",    {31'b0, obiErr},    32'h0);
    checkOutput("mid_rst_busy",   {31'b0, busy},      32'h0);
    checkOutput("mid_rst_gnt",    {31'b0, obiGnt},    32'h1);
    checkOutput("mid_rst_memreq", {31'b0, memReq},    32'h0);
    expQ.delete();
    lastMemAddr = 12'h0;
    @(posedge clk);
    #3 rst = 1'b0;
    obiRready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("post_rst_rvalid", {31'b0, obiRvalid}, 32'h0);
      checkOutput("post_rst_busy",   {31'b0, busy},      32'h0);
      checkOutput("post_rst_gnt",    {31'b0, obiGnt},    32'h1);
      @(posedge clk);
      #1;
    end
    applyStimulus(32'h8, WORDS[2], 1'b0);
    idle(3);

    waitCycles = 0;
    while (expQ.size() != 0 && waitCycles < 50) begin
      @(posedge clk);
      waitCycles++;
    end
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
